// File: rtl/send_seg_ctrl.sv
// Per-flow segment sender: reads flow pointers, sizes one segment against the peer window and MSS,
// emits it and writes back next_send. Optional counters behind SEND_SEG_CTRL_STATS_EN.
module send_seg_ctrl #(
    parameter int PTR_W        = 11,
    parameter int WIN_SIZE_W   = 16,
    parameter int MAX_SEG_SIZE = 1024,
    parameter int FLOWID_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  sched_req_val,
    input  logic [FLOWID_W-1:0]   sched_req_flowid,
    output logic                  sched_req_rdy,

    output logic                  state_rd_req_val,
    output logic [FLOWID_W-1:0]   state_rd_req_flowid,
    input  logic                  state_rd_req_rdy,

    input  logic                  state_rd_resp_val,
    output logic                  state_rd_resp_rdy,
    input  logic [PTR_W:0]        state_rd_resp_trail_ptr,
    input  logic [PTR_W:0]        state_rd_resp_lead_ptr,
    input  logic [PTR_W:0]        state_rd_resp_next_send_ptr,
    input  logic [WIN_SIZE_W-1:0] state_rd_resp_curr_win,

    output logic                  send_req_val,
    input  logic                  send_req_rdy,
    output logic [FLOWID_W-1:0]   send_req_flowid,
    output logic [PTR_W:0]        send_req_start_ptr,
    output logic [PTR_W:0]        send_req_len,

    output logic                  next_send_wr_val,
    input  logic                  next_send_wr_rdy,
    output logic [FLOWID_W-1:0]   next_send_wr_flowid,
    output logic [PTR_W:0]        next_send_wr_ptr
`ifdef SEND_SEG_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_segs_sent,
    output logic [31:0]           stat_zero_seg,
    output logic [31:0]           stat_bytes_sent
`endif
);

    localparam int PW = PTR_W + 1;
    localparam int CW = ((WIN_SIZE_W > PW) ? WIN_SIZE_W : PW) + 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SEND, WB} state_t;

    state_t                state;
    logic [FLOWID_W-1:0]   flowid_q;
    logic [PTR_W:0]        trail_q, lead_q, next_send_q, seg_q;
    logic [WIN_SIZE_W-1:0] win_q;

    logic [PTR_W:0]        c_trail, c_lead, c_next_send;
    logic [WIN_SIZE_W-1:0] c_win;
    logic [PTR_W:0]        unsent, inflight, seg_size;
    logic [CW-1:0]         win_ext, infl_ext, unsent_ext, max_ext, usable, min_a, min_b;

    // The sizer sees the live response in RD_WAIT and the held copy afterwards,
    // so the writeback pointer comes from the same arithmetic as the decision.
    always_comb begin
        c_trail     = (state == RD_WAIT) ? state_rd_resp_trail_ptr     : trail_q;
        c_lead      = (state == RD_WAIT) ? state_rd_resp_lead_ptr      : lead_q;
        c_next_send = (state == RD_WAIT) ? state_rd_resp_next_send_ptr : next_send_q;
        c_win       = (state == RD_WAIT) ? state_rd_resp_curr_win      : win_q;

        unsent     = c_lead - c_next_send;
        inflight   = c_next_send - c_trail;
        win_ext    = CW'(c_win);
        infl_ext   = CW'(inflight);
        unsent_ext = CW'(unsent);
        max_ext    = CW'(MAX_SEG_SIZE);
        usable     = (win_ext > infl_ext) ? (win_ext - infl_ext) : '0;
        min_a      = (unsent_ext < usable) ? unsent_ext : usable;
        min_b      = (min_a < max_ext) ? min_a : max_ext;
        seg_size   = min_b[PTR_W:0];
    end

    assign state_rd_req_flowid = flowid_q;
    assign send_req_flowid     = flowid_q;
    assign send_req_start_ptr  = next_send_q;
    assign send_req_len        = seg_q;
    assign next_send_wr_flowid = flowid_q;
    assign next_send_wr_ptr    = next_send_q + seg_size;

`ifdef SEND_SEG_CTRL_STATS_EN
    logic [32:0] bytes_sum;
    assign bytes_sum = {1'b0, stat_bytes_sent} + 33'(seg_q);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            flowid_q          <= '0;
            trail_q           <= '0;
            lead_q            <= '0;
            next_send_q       <= '0;
            win_q             <= '0;
            seg_q             <= '0;
            sched_req_rdy     <= 1'b1;
            state_rd_req_val  <= 1'b0;
            state_rd_resp_rdy <= 1'b0;
            send_req_val      <= 1'b0;
            next_send_wr_val  <= 1'b0;
`ifdef SEND_SEG_CTRL_STATS_EN
            stat_segs_sent    <= '0;
            stat_zero_seg     <= '0;
            stat_bytes_sent   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sched_req_val && sched_req_rdy) begin
                        flowid_q         <= sched_req_flowid;
                        sched_req_rdy    <= 1'b0;
                        state_rd_req_val <= 1'b1;
                        state            <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (state_rd_req_val && state_rd_req_rdy) begin
                        state_rd_req_val  <= 1'b0;
                        state_rd_resp_rdy <= 1'b1;
                        state             <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (state_rd_resp_val && state_rd_resp_rdy) begin
                        trail_q           <= state_rd_resp_trail_ptr;
                        lead_q            <= state_rd_resp_lead_ptr;
                        next_send_q       <= state_rd_resp_next_send_ptr;
                        win_q             <= state_rd_resp_curr_win;
                        seg_q             <= seg_size;
                        state_rd_resp_rdy <= 1'b0;
                        if (seg_size != '0) begin
                            send_req_val <= 1'b1;
                            state        <= SEND;
                        end else begin
                            sched_req_rdy <= 1'b1;
                            state         <= IDLE;
`ifdef SEND_SEG_CTRL_STATS_EN
                            if (stat_zero_seg != '1) stat_zero_seg <= stat_zero_seg + 32'd1;
`endif
                        end
                    end
                end
                SEND: begin
                    if (send_req_val && send_req_rdy) begin
                        send_req_val     <= 1'b0;
                        next_send_wr_val <= 1'b1;
                        state            <= WB;
`ifdef SEND_SEG_CTRL_STATS_EN
                        if (stat_segs_sent != '1) stat_segs_sent <= stat_segs_sent + 32'd1;
                        stat_bytes_sent <= bytes_sum[32] ? '1 : bytes_sum[31:0];
`endif
                    end
                end
                WB: begin
                    if (next_send_wr_val && next_send_wr_rdy) begin
                        next_send_wr_val <= 1'b0;
                        sched_req_rdy    <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: begin
                    sched_req_rdy     <= 1'b1;
                    state_rd_req_val  <= 1'b0;
                    state_rd_resp_rdy <= 1'b0;
                    send_req_val      <= 1'b0;
                    next_send_wr_val  <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_send_seg_ctrl.sv
// Directed bench for send_seg_ctrl: segment sizing, pointer wrap, back-pressure and reset abandonment.
module tb_send_seg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sched_req_val, sched_req_rdy;
    logic [2:0]  sched_req_flowid;
    logic        state_rd_req_val, state_rd_req_rdy;
    logic [2:0]  state_rd_req_flowid;
    logic        state_rd_resp_val, state_rd_resp_rdy;
    logic [11:0] resp_trail, resp_lead, resp_next_send;
    logic [15:0] resp_win;
    logic        send_req_val, send_req_rdy;
    logic [2:0]  send_req_flowid;
    logic [11:0] send_req_start_ptr, send_req_len;
    logic        next_send_wr_val, next_send_wr_rdy;
    logic [2:0]  next_send_wr_flowid;
    logic [11:0] next_send_wr_ptr;
`ifdef SEND_SEG_CTRL_STATS_EN
    logic [31:0] stat_segs_sent, stat_zero_seg, stat_bytes_sent;
`endif

    send_seg_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .sched_req_val               (sched_req_val),
        .sched_req_flowid            (sched_req_flowid),
        .sched_req_rdy               (sched_req_rdy),
        .state_rd_req_val            (state_rd_req_val),
        .state_rd_req_flowid         (state_rd_req_flowid),
        .state_rd_req_rdy            (state_rd_req_rdy),
        .state_rd_resp_val           (state_rd_resp_val),
        .state_rd_resp_rdy           (state_rd_resp_rdy),
        .state_rd_resp_trail_ptr     (resp_trail),
        .state_rd_resp_lead_ptr      (resp_lead),
        .state_rd_resp_next_send_ptr (resp_next_send),
        .state_rd_resp_curr_win      (resp_win),
        .send_req_val                (send_req_val),
        .send_req_rdy                (send_req_rdy),
        .send_req_flowid             (send_req_flowid),
        .send_req_start_ptr          (send_req_start_ptr),
        .send_req_len                (send_req_len),
        .next_send_wr_val            (next_send_wr_val),
        .next_send_wr_rdy            (next_send_wr_rdy),
        .next_send_wr_flowid         (next_send_wr_flowid),
        .next_send_wr_ptr            (next_send_wr_ptr)
`ifdef SEND_SEG_CTRL_STATS_EN
        ,
        .stat_segs_sent              (stat_segs_sent),
        .stat_zero_seg               (stat_zero_seg),
        .stat_bytes_sent             (stat_bytes_sent)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_segs = 0, exp_zero = 0, exp_bytes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input logic [11:0] tr, input logic [11:0] ld, input logic [11:0] ns,
                            input logic [15:0] win);
        resp_trail = tr; resp_lead = ld; resp_next_send = ns; resp_win = win;
        state_rd_resp_val = 1'b1;
    endtask

    // One flow with every rdy high; exp_len==0 means a zero-size return.
    task automatic run_flow(input string tag, input logic [2:0] fid, input logic [11:0] tr,
                            input logic [11:0] ld, input logic [11:0] ns, input logic [15:0] win,
                            input logic [11:0] exp_len, input logic [11:0] exp_wb);
        set_resp(tr, ld, ns, win);
        state_rd_req_rdy = 1'b1; send_req_rdy = 1'b1; next_send_wr_rdy = 1'b1;
        sched_req_flowid = fid; sched_req_val = 1'b1;
        step;
        sched_req_val = 1'b0;
        chk({tag, ".rdreq_val"}, 32'(state_rd_req_val), 32'd1);
        chk({tag, ".rdreq_fid"}, 32'(state_rd_req_flowid), 32'(fid));
        chk({tag, ".sched_busy"}, 32'(sched_req_rdy), 32'd0);
        step;
        chk({tag, ".resp_rdy"}, 32'(state_rd_resp_rdy), 32'd1);
        step;
        if (exp_len != 12'd0) begin
            chk({tag, ".send_val"}, 32'(send_req_val), 32'd1);
            chk({tag, ".send_fid"}, 32'(send_req_flowid), 32'(fid));
            chk({tag, ".start"}, 32'(send_req_start_ptr), 32'(ns));
            chk({tag, ".len"}, 32'(send_req_len), 32'(exp_len));
            exp_segs++; exp_bytes += int'(exp_len);
            step;
            chk({tag, ".wb_val"}, 32'(next_send_wr_val), 32'd1);
            chk({tag, ".wb_fid"}, 32'(next_send_wr_flowid), 32'(fid));
            chk({tag, ".wb_ptr"}, 32'(next_send_wr_ptr), 32'(exp_wb));
            chk({tag, ".send_drop"}, 32'(send_req_val), 32'd0);
            step;
            chk({tag, ".idle_wb"}, 32'(next_send_wr_val), 32'd0);
            chk({tag, ".idle_rdy"}, 32'(sched_req_rdy), 32'd1);
        end else begin
            exp_zero++;
            chk({tag, ".no_send"}, 32'(send_req_val), 32'd0);
            chk({tag, ".no_wb"}, 32'(next_send_wr_val), 32'd0);
            chk({tag, ".idle_rdy"}, 32'(sched_req_rdy), 32'd1);
            step;
            chk({tag, ".no_wb2"}, 32'(next_send_wr_val), 32'd0);
        end
        state_rd_resp_val = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sched_req_val = 1'b0; sched_req_flowid = '0;
        state_rd_req_rdy = 1'b0; send_req_rdy = 1'b0; next_send_wr_rdy = 1'b0;
        state_rd_resp_val = 1'b0;
        resp_trail = '0; resp_lead = '0; resp_next_send = '0; resp_win = '0;
        step; step;
        chk("rst.send_val", 32'(send_req_val), 32'd0);
        chk("rst.wb_val", 32'(next_send_wr_val), 32'd0);
        chk("rst.rdreq_val", 32'(state_rd_req_val), 32'd0);
        chk("rst.resp_rdy", 32'(state_rd_resp_rdy), 32'd0);
        rst = 1'b0;
        step;
        chk("rst.sched_rdy", 32'(sched_req_rdy), 32'd1);

        // Reset while a segment waits in SEND; a stale response stays on the bus afterwards.
        set_resp(12'h000, 12'h800, 12'h300, 16'h0400);
        state_rd_req_rdy = 1'b1; send_req_rdy = 1'b0; next_send_wr_rdy = 1'b1;
        sched_req_flowid = 3'd3; sched_req_val = 1'b1;
        step;
        sched_req_val = 1'b0;
        step; step;
        chk("rsend.send_val", 32'(send_req_val), 32'd1);
        rst = 1'b1;
        step;
        chk("rsend.send_off", 32'(send_req_val), 32'd0);
        chk("rsend.wb_off", 32'(next_send_wr_val), 32'd0);
        chk("rsend.rdreq_off", 32'(state_rd_req_val), 32'd0);
        rst = 1'b0; send_req_rdy = 1'b1;
        step;
        chk("rsend.stale_rdy", 32'(state_rd_resp_rdy), 32'd0);
        chk("rsend.no_wb", 32'(next_send_wr_val), 32'd0);
        chk("rsend.sched_rdy", 32'(sched_req_rdy), 32'd1);
        step;
        chk("rsend.no_wb2", 32'(next_send_wr_val), 32'd0);
        chk("rsend.no_send2", 32'(send_req_val), 32'd0);
        run_flow("after_rst", 3'd3, 12'h000, 12'h800, 12'h300, 16'h0400, 12'h100, 12'h400);

        run_flow("mss",      3'd2, 12'h100, 12'h900, 12'h100, 16'hFFFF, 12'h400, 12'h500);
        run_flow("win_lim",  3'd4, 12'h000, 12'h800, 12'h300, 16'h0400, 12'h100, 12'h400);
        run_flow("win_zero", 3'd5, 12'h000, 12'h800, 12'h300, 16'h0200, 12'h000, 12'h000);
        run_flow("no_data",  3'd6, 12'h000, 12'h500, 12'h500, 16'hFFFF, 12'h000, 12'h000);
        run_flow("wrap",     3'd7, 12'hFF0, 12'h010, 12'hFF0, 16'hFFFF, 12'h020, 12'h010);
        run_flow("unsent",   3'd0, 12'h010, 12'h050, 12'h020, 16'h0100, 12'h030, 12'h050);

        // Send stalled for 10 cycles with a second request waiting behind it.
        set_resp(12'h100, 12'h900, 12'h100, 16'hFFFF);
        send_req_rdy = 1'b0;
        sched_req_flowid = 3'd1; sched_req_val = 1'b1;
        step;
        sched_req_flowid = 3'd5;
        step; step;
        for (int i = 0; i < 10; i++) begin
            chk("bp.send_val", 32'(send_req_val), 32'd1);
            chk("bp.fid", 32'(send_req_flowid), 32'd1);
            chk("bp.start", 32'(send_req_start_ptr), 32'h100);
            chk("bp.len", 32'(send_req_len), 32'h400);
            chk("bp.sched_rdy", 32'(sched_req_rdy), 32'd0);
            step;
        end
        send_req_rdy = 1'b1;
        step;
        chk("bp.wb_val", 32'(next_send_wr_val), 32'd1);
        chk("bp.wb_ptr", 32'(next_send_wr_ptr), 32'h500);
        chk("bp.wb_sched", 32'(sched_req_rdy), 32'd0);
        step;
        chk("bp.idle_rdy", 32'(sched_req_rdy), 32'd1);
        chk("bp.idle_rdreq", 32'(state_rd_req_val), 32'd0);
        step;
        sched_req_val = 1'b0;
        chk("bp.second_rdreq", 32'(state_rd_req_val), 32'd1);
        chk("bp.second_fid", 32'(state_rd_req_flowid), 32'd5);
        step; step;
        chk("bp.second_send", 32'(send_req_val), 32'd1);
        chk("bp.second_sfid", 32'(send_req_flowid), 32'd5);
        step; step;
        chk("bp.second_done", 32'(sched_req_rdy), 32'd1);
        exp_segs += 2; exp_bytes += 2 * 'h400;
        state_rd_resp_val = 1'b0;

`ifdef SEND_SEG_CTRL_STATS_EN
        chk("stat.segs", stat_segs_sent, 32'(exp_segs));
        chk("stat.zero", stat_zero_seg, 32'(exp_zero));
        chk("stat.bytes", stat_bytes_sent, 32'(exp_bytes));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
